// File: rtl/wait_seq_thread.sv
// Looping multi-step thread: one body cycle per step, then a per-step wait.
// Wait lengths live in a small table that can be rewritten at runtime.
module wait_seq_thread #(
    parameter int WIDTH        = 32,
    parameter int NUM_STEPS    = 4,
    parameter int CNT_W        = 8,
    parameter int DEFAULT_WAIT = 4,
    localparam int STEP_W      = (NUM_STEPS > 2) ? $clog2(NUM_STEPS) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     hold,
    input  logic                     restart,
    input  logic signed [WIDTH-1:0]  in1,
    input  logic                     cfg_we,
    input  logic [STEP_W-1:0]        cfg_addr,
    input  logic [CNT_W-1:0]         cfg_wait,
    output logic signed [WIDTH-1:0]  out1,
    output logic                     out_valid,
    output logic [STEP_W-1:0]        step,
    output logic                     in_wait
);

    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);
    localparam logic [STEP_W:0]   STEP_CNT  = (STEP_W + 1)'(NUM_STEPS);
    localparam logic [CNT_W-1:0]  RST_WAIT  = CNT_W'(DEFAULT_WAIT);
    localparam logic [CNT_W-1:0]  ONE       = CNT_W'(1);

    logic [0:0]        state;
    logic [CNT_W-1:0]  wait_counter;
    logic [CNT_W-1:0]  wait_table [NUM_STEPS];

    logic [CNT_W-1:0]  cur_wait;
    logic [CNT_W-1:0]  eff_wait;
    logic [STEP_W-1:0] step_next;
    logic [WIDTH-1:0]  step_ext;
    logic              cfg_hit;

    // Body-cycle helpers: effective wait (0 behaves as 1) and wrapped step.
    always_comb begin
        cur_wait  = wait_table[step];
        eff_wait  = (cur_wait == '0) ? ONE : cur_wait;
        step_next = (step == LAST_STEP) ? '0 : step + STEP_W'(1);
        step_ext  = WIDTH'(step);
        cfg_hit   = cfg_we && ({1'b0, cfg_addr} < STEP_CNT);
    end

    // Wait table: reset to defaults, writable regardless of hold/restart.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_STEPS; i++) begin
                wait_table[i] <= RST_WAIT;
            end
        end else if (cfg_hit) begin
            wait_table[cfg_addr] <= cfg_wait;
        end
    end

    // Thread sequencer: body cycle in RUN, countdown in WAIT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= RUN;
            step         <= '0;
            wait_counter <= '0;
            out1         <= '0;
            out_valid    <= 1'b0;
        end else if (restart) begin
            state        <= RUN;
            step         <= '0;
            wait_counter <= '0;
            out_valid    <= 1'b0;
        end else if (hold) begin
            out_valid <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    out1      <= in1 + step_ext;
                    out_valid <= 1'b1;
                    if (eff_wait == ONE) begin
                        step <= step_next;
                    end else begin
                        wait_counter <= eff_wait - ONE;
                        state        <= WAIT;
                    end
                end
                default: begin
                    out_valid    <= 1'b0;
                    wait_counter <= wait_counter - ONE;
                    if (wait_counter == ONE) begin
                        state <= RUN;
                        step  <= step_next;
                    end
                end
            endcase
        end
    end

    assign in_wait = (state == WAIT);

endmodule
